// File: rtl/cpu_pkg.sv
// Shared CPU definitions: interrupt sequencer state encoding and the fixed
// vector addresses also used by the PC unit.
package cpu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_SAFE = 3'd1,
      ST_FLUSH     = 3'd2,
      ST_FETCH_VEC = 3'd3,
      ST_LOAD_PC   = 3'd4,
      ST_IN_ISR    = 3'd5
   } seq_state_t;

   localparam logic [7:0] RESET_VEC_ADDR = 8'h00;
   localparam logic [7:0] INT_VEC_ADDR   = 8'h01;

endpackage

// File: rtl/int_edge_latch.sv
// Rising-edge detector on the interrupt pin feeding a one-deep pending flag.
// A new edge always wins over a simultaneous clear so no request is lost.
module int_edge_latch (
   input  logic clk,
   input  logic rst,
   input  logic i_sig,
   input  logic i_clr,
   output logic o_pending
);

   logic r_prev;
   logic r_pending;
   logic w_rise;

   assign w_rise    = i_sig & ~r_prev;
   assign o_pending = r_pending;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev    <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         r_prev <= i_sig;
         if (w_rise)
            r_pending <= 1'b1;
         else if (i_clr)
            r_pending <= 1'b0;
      end
   end

endmodule

// File: rtl/int_seq_ctrl.sv
// Interrupt entry/exit sequencer: waits for a safe pipeline boundary, flushes,
// saves the resume PC, fetches the ISR vector and redirects the PC.
module int_seq_ctrl
   import cpu_pkg::*;
#(
   parameter int              AW       = 8,
   parameter int              DW       = 8,
   parameter logic [AW-1:0]   VEC_ADDR = AW'(INT_VEC_ADDR),
   parameter int              MEM_LAT  = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          int_sig,
   input  logic          stall,
   input  logic          branch_pending,
   input  logic [AW-1:0] pc_next,
   input  logic          rti_retire,
   input  logic [DW-1:0] vec_data,
   output logic          flush,
   output logic          pc_hold,
   output logic          save_pc,
   output logic [AW-1:0] save_val,
   output logic          vec_rd,
   output logic [AW-1:0] vec_addr,
   output logic          pc_load,
   output logic [AW-1:0] pc_load_val,
   output logic          int_active
);

   localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

   seq_state_t    r_state;
   seq_state_t    w_nxt_state;
   logic          w_pending;
   logic          w_clr;
   logic [1:0]    r_cnt;
   logic [AW-1:0] r_ret_pc;
   logic [AW-1:0] r_pc_load_val;
   logic          r_flush, r_pc_hold, r_save_pc, r_vec_rd, r_pc_load, r_int_active;

   assign w_clr = (r_state == ST_FLUSH);

   int_edge_latch u_edge_latch (
      .clk       (clk),
      .rst       (rst),
      .i_sig     (int_sig),
      .i_clr     (w_clr),
      .o_pending (w_pending)
   );

   always_comb begin
      w_nxt_state = r_state;
      case (r_state)
         ST_IDLE:      if (w_pending) w_nxt_state = ST_WAIT_SAFE;
         ST_WAIT_SAFE: if (!stall && !branch_pending) w_nxt_state = ST_FLUSH;
         ST_FLUSH:     w_nxt_state = ST_FETCH_VEC;
         ST_FETCH_VEC: if (r_cnt == 2'd0) w_nxt_state = ST_LOAD_PC;
         ST_LOAD_PC:   w_nxt_state = ST_IN_ISR;
         ST_IN_ISR:    if (rti_retire) w_nxt_state = ST_IDLE;
         default:      w_nxt_state = ST_IDLE;
      endcase
   end

   // Strobes are registered from the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_cnt         <= 2'd0;
         r_ret_pc      <= '0;
         r_pc_load_val <= '0;
         r_flush       <= 1'b0;
         r_pc_hold     <= 1'b0;
         r_save_pc     <= 1'b0;
         r_vec_rd      <= 1'b0;
         r_pc_load     <= 1'b0;
         r_int_active  <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         if (r_state == ST_WAIT_SAFE && w_nxt_state == ST_FLUSH)
            r_ret_pc <= pc_next;
         if (r_state == ST_FLUSH)
            r_cnt <= CNT_INIT;
         else if (r_state == ST_FETCH_VEC && r_cnt != 2'd0)
            r_cnt <= r_cnt - 2'd1;
         if (r_state == ST_FETCH_VEC && r_cnt == 2'd0)
            r_pc_load_val <= AW'(vec_data);
         r_flush      <= (w_nxt_state == ST_FLUSH);
         r_save_pc    <= (w_nxt_state == ST_FLUSH);
         r_pc_hold    <= (w_nxt_state == ST_FLUSH) || (w_nxt_state == ST_FETCH_VEC) ||
                         (w_nxt_state == ST_LOAD_PC);
         r_vec_rd     <= (w_nxt_state == ST_FETCH_VEC);
         r_pc_load    <= (w_nxt_state == ST_LOAD_PC);
         r_int_active <= (w_nxt_state == ST_IN_ISR);
      end
   end

   assign flush       = r_flush;
   assign pc_hold     = r_pc_hold;
   assign save_pc     = r_save_pc;
   assign save_val    = r_save_pc ? r_ret_pc : '0;
   assign vec_rd      = r_vec_rd;
   assign vec_addr    = r_vec_rd ? VEC_ADDR : '0;
   assign pc_load     = r_pc_load;
   assign pc_load_val = r_pc_load_val;
   assign int_active  = r_int_active;

endmodule

// File: doc/int_seq_ctrl.md
Name: int_seq_ctrl

Overview:
- Interrupt entry/exit sequencer for the 8-bit pipelined CPU wrapper.
- Latches the external int_sig request and waits for a safe pipeline boundary with no stall and no branch in flight.
- Then flushes the front end, saves the resume PC, reads the interrupt vector from memory address VEC_ADDR and redirects the PC.
- Tracks ISR residency until RTI retires; sits between the top-level int_sig pin, the PC register, hazard unit and memory read port.

Parameters:
AW, 8, address/PC width
DW, 8, memory data width
VEC_ADDR, 8'h01, memory address holding the ISR start address
MEM_LAT, 1, cycles from vec_rd assertion to valid vec_data (1..3)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
int_sig  in  1  external interrupt request, synchronous level
stall  in  1  pipeline stall from hazard unit
branch_pending  in  1  taken branch/jump/call in flight (IF..EX)
pc_next  in  AW  PC of oldest unretired fetched instruction (resume point)
rti_retire  in  1  RTI instruction retires this cycle
vec_data  in  DW  memory read data for vector fetch
flush  out  1  squash IF/ID and ID/EX contents
pc_hold  out  1  freeze PC and fetch during sequence
save_pc  out  1  push save_val to stack (one-cycle strobe)
save_val  out  AW  return address to push
vec_rd  out  1  memory read request for vector
vec_addr  out  AW  vector read address
pc_load  out  1  load PC with pc_load_val (one-cycle strobe)
pc_load_val  out  AW  ISR entry address
int_active  out  1  CPU executing ISR

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE, pending=0, wait counter=0, ret_pc=0, int_sig edge register=0; every output 0. Reset mid-sequence aborts at once, with no partial save/load strobes.
- Request capture: pending is set on int_sig rising edge (int_sig=1 and previous int_sig=0). int_sig held high N cycles gives exactly one request. pending is cleared in FLUSH. A second edge while pending=1 is absorbed. Request depth is one.
- FSM states: IDLE, WAIT_SAFE, FLUSH, FETCH_VEC, LOAD_PC, IN_ISR.
  - IDLE: pending=1 -> WAIT_SAFE next cycle.
  - WAIT_SAFE: pc_hold=0. When stall=0 and branch_pending=0, capture ret_pc=pc_next and go to FLUSH. Otherwise stay, with no timeout.
  - FLUSH (1 cycle): flush=1, pc_hold=1, save_pc=1, save_val=ret_pc. Clear pending. -> FETCH_VEC.
  - FETCH_VEC (MEM_LAT cycles): pc_hold=1, vec_rd=1, vec_addr=VEC_ADDR. The counter counts MEM_LAT-1 down to 0. vec_data is registered into pc_load_val on the last cycle. -> LOAD_PC.
  - LOAD_PC (1 cycle): pc_hold=1, pc_load=1, pc_load_val=registered vector. -> IN_ISR.
  - IN_ISR: int_active=1, all other strobes 0. rti_retire=1 -> IDLE next cycle, and int_active drops with the state change.
- Latency: from the int_sig edge with the pipeline already safe, pc_load asserts at edge+3+MEM_LAT cycles, i.e. edge+4 for MEM_LAT=1.
- No nesting:
  - An edge seen in FLUSH..IN_ISR sets pending.
  - That request is serviced after return: IDLE -> WAIT_SAFE.
  - Exception: an edge coinciding with the FLUSH-cycle clear is preserved; set wins over clear.
- rti_retire outside IN_ISR is ignored.
- int_sig edge in the same cycle as rti_retire: the IN_ISR -> IDLE transition occurs and pending=1, so WAIT_SAFE follows.
- Widths: save_val, pc_load_val and vec_addr are AW. vec_data is DW and is truncated or zero-extended to AW if widths differ.
- Outputs are registered or decoded from state only, with no combinational path from inputs to outputs.

Decomposition:
- Shared package cpu_pkg: state encoding constants (IDLE=0 .. IN_ISR=5), VEC_ADDR default, and reset/interrupt vector address constants shared with the PC unit.
- One natural sub-module, int_edge_latch: rising-edge detect plus pending set/clear register, with set priority over clear.
- FSM, counter and vector register stay in int_seq_ctrl.

Test Plan:
1. Basic entry: mem[1]=8'h80, stall=0, branch_pending=0, pc_next=8'h05, one-cycle int_sig pulse. Required: flush/save_pc one cycle with save_val=8'h05; vec_rd with vec_addr=8'h01; pc_load with pc_load_val=8'h80 exactly 4 cycles after the edge; int_active=1 afterwards.
2. Safe-point wait: int_sig pulse while stall=1 for 3 cycles, then branch_pending=1 for 2 cycles. Required: no flush until both inputs are low; ret_pc captured on the first safe cycle.
3. Held and nested request: int_sig high for 5 cycles gives one entry only. A new edge during IN_ISR followed by rti_retire gives int_active 1->0, then WAIT_SAFE and a second entry with save_val = pc_next at that time.
4. Latency parameter: MEM_LAT=3, vector 8'h80 presented 3 cycles after vec_rd. Required: vec_rd high 3 cycles; pc_load_val=8'h80 with pc_load at edge+6.
5. Reset mid-sequence: rst=1 during FETCH_VEC. Required: at the next posedge all outputs 0, state IDLE, pending cleared; no pc_load afterwards without a new edge.
6. Spurious RTI: rti_retire=1 in IDLE. Required: no output change. Simultaneous int_sig edge and rti_retire in IN_ISR gives a re-entry sequence.
